// File: rtl/mailbox_write_arbiter.sv
// Round-robin N-master write front end for the mailbox register file.
// Each winning request is checked against its master's writable-address bitmap.
module mailbox_write_arbiter #(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter logic [NUM_MASTERS*(2**ADDR_WIDTH)-1:0] WRITABLE_MAP = '0,
    parameter int VIOL_CNT_WIDTH = 8,
    localparam int MIDX_WIDTH    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                                   clk,
    input  logic                                   i_resetn,
    input  logic [NUM_MASTERS-1:0]                 i_req_valid,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]      i_req_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]      i_req_data,
    output logic [NUM_MASTERS-1:0]                 o_req_ready,
    output logic [NUM_MASTERS-1:0]                 o_req_denied,
    output logic                                   o_wr_en,
    output logic [ADDR_WIDTH-1:0]                  o_wr_addr,
    output logic [DATA_WIDTH-1:0]                  o_wr_data,
    output logic [MIDX_WIDTH-1:0]                  o_wr_master,
    input  logic                                   i_wr_ready,
    input  logic                                   i_clear_violations,
    output logic [NUM_MASTERS*VIOL_CNT_WIDTH-1:0]  o_violation_count
);

    localparam int NUM_ADDRS = 2**ADDR_WIDTH;
    localparam logic [VIOL_CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [MIDX_WIDTH-1:0] LAST_RESET = MIDX_WIDTH'(NUM_MASTERS - 1);

    logic [MIDX_WIDTH-1:0] last_grant;
    logic                  stage_free;
    logic                  found;
    logic                  consume;
    logic                  permitted;
    logic [MIDX_WIDTH-1:0] grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;

    assign stage_free = !o_wr_en || i_wr_ready;

    // Search from the master after the last one served, wrapping around.
    always_comb begin
        int cand;
        cand       = 0;
        found      = 1'b0;
        permitted  = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int off = 1; off <= NUM_MASTERS; off++) begin
            cand = (int'(last_grant) + off) % NUM_MASTERS;
            if (!found && i_req_valid[cand]) begin
                found      = 1'b1;
                grant_idx  = MIDX_WIDTH'(cand);
                grant_addr = i_req_addr[cand*ADDR_WIDTH +: ADDR_WIDTH];
                grant_data = i_req_data[cand*DATA_WIDTH +: DATA_WIDTH];
                permitted  = WRITABLE_MAP[cand*NUM_ADDRS + int'(i_req_addr[cand*ADDR_WIDTH +: ADDR_WIDTH])];
            end
        end
    end

    // Gating with reset keeps requests from being acknowledged while held in reset.
    assign consume = found && stage_free && i_resetn;

    always_comb begin
        o_req_ready  = '0;
        o_req_denied = '0;
        if (consume) begin
            o_req_ready[grant_idx]  = 1'b1;
            o_req_denied[grant_idx] = !permitted;
        end
    end

    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            last_grant <= LAST_RESET;
        end else if (consume) begin
            last_grant <= grant_idx;
        end
    end

    // Output stage: reload on a permitted grant, otherwise drain when accepted.
    always_ff @(posedge clk or negedge i_resetn) begin
        if (!i_resetn) begin
            o_wr_en     <= 1'b0;
            o_wr_addr   <= '0;
            o_wr_data   <= '0;
            o_wr_master <= '0;
        end else if (consume && permitted) begin
            o_wr_en     <= 1'b1;
            o_wr_addr   <= grant_addr;
            o_wr_data   <= grant_data;
            o_wr_master <= grant_idx;
        end else if (i_wr_ready) begin
            o_wr_en     <= 1'b0;
        end
    end

    for (genvar m = 0; m < NUM_MASTERS; m++) begin : g_viol
        logic [VIOL_CNT_WIDTH-1:0] cnt;
        logic                      deny;

        assign deny = o_req_denied[m];

        // A clear coinciding with a denial counts that denial.
        always_ff @(posedge clk or negedge i_resetn) begin
            if (!i_resetn) begin
                cnt <= '0;
            end else if (i_clear_violations) begin
                cnt <= VIOL_CNT_WIDTH'(deny);
            end else if (deny && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign o_violation_count[m*VIOL_CNT_WIDTH +: VIOL_CNT_WIDTH] = cnt;
    end

endmodule

// File: tb/tb_mailbox_write_arbiter.sv
// Bench for mailbox_write_arbiter: vector table, directed corner sequences,
// and a write scoreboard fed from observed grants and the bench's own map.
module tb_mailbox_write_arbiter;

    localparam int NM = 3;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int NA = 256;

    function automatic logic [NM*NA-1:0] build_map();
        logic [NM*NA-1:0] mp;
        mp = '0;
        mp[0*NA + 8'h0B] = 1'b1; mp[0*NA + 8'h0C] = 1'b1; mp[0*NA + 8'h0D] = 1'b1;
        mp[0*NA + 8'h0F] = 1'b1; mp[0*NA + 8'h10] = 1'b1; mp[0*NA + 8'h11] = 1'b1;
        mp[0*NA + 8'h12] = 1'b1; mp[0*NA + 8'h61] = 1'b1;
        for (int a = 8'h80; a <= 8'hBF; a++) mp[0*NA + a] = 1'b1;
        mp[1*NA + 8'h0B] = 1'b1; mp[1*NA + 8'h0C] = 1'b1; mp[1*NA + 8'h0D] = 1'b1;
        mp[1*NA + 8'h0F] = 1'b1; mp[1*NA + 8'h13] = 1'b1; mp[1*NA + 8'h60] = 1'b1;
        mp[1*NA + 8'h62] = 1'b1;
        for (int a = 8'hC0; a <= 8'hFF; a++) mp[1*NA + a] = 1'b1;
        mp[2*NA + 8'h0F] = 1'b1;
        return mp;
    endfunction

    localparam logic [NM*NA-1:0] MAP = build_map();

    logic             clk;
    logic             rst_n;
    logic [NM-1:0]    req_valid;
    logic [NM*AW-1:0] req_addr;
    logic [NM*DW-1:0] req_data;
    logic [NM-1:0]    req_ready;
    logic [NM-1:0]    req_denied;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [1:0]       wr_master;
    logic             wr_ready;
    logic             clear_viol;
    logic [NM*CW-1:0] viol_count;

    mailbox_write_arbiter #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .WRITABLE_MAP(MAP), .VIOL_CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .i_resetn(rst_n),
        .i_req_valid(req_valid), .i_req_addr(req_addr), .i_req_data(req_data),
        .o_req_ready(req_ready), .o_req_denied(req_denied),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_wr_master(wr_master), .i_wr_ready(wr_ready),
        .i_clear_violations(clear_viol), .o_violation_count(viol_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt(input int m);
        return {24'd0, viol_count[m*CW +: CW]};
    endfunction

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    master;
    } wr_t;

    wr_t  sb[$];
    wr_t  exp_w;
    bit   mon_en = 1'b0;

    always @(negedge rst_n) sb.delete();

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (wr_en && wr_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_write: got addr 0x%0h data 0x%0h with nothing expected", wr_addr, wr_data);
                end else begin
                    exp_w = sb.pop_front();
                    check("sb_wr_addr", {24'd0, wr_addr}, {24'd0, exp_w.addr});
                    check("sb_wr_data", {24'd0, wr_data}, {24'd0, exp_w.data});
                    check("sb_wr_master", {30'd0, wr_master}, {30'd0, exp_w.master});
                end
            end
            if (req_ready != '0) begin
                check("ready_onehot", {31'd0, $onehot(req_ready)}, 32'd1);
                for (int m = 0; m < NM; m++) begin
                    if (req_ready[m]) begin
                        logic [AW-1:0] a;
                        logic          p;
                        a = req_addr[m*AW +: AW];
                        p = MAP[m*NA + int'(a)];
                        check("denied_vs_map", {31'd0, req_denied[m]}, {31'd0, !p});
                        if (p) sb.push_back('{addr: a, data: req_data[m*DW +: DW], master: 2'(m)});
                    end
                end
            end
            if ((req_denied & ~req_ready) != '0)
                check("denied_without_ready", {29'd0, req_denied}, {29'd0, req_denied & req_ready});
        end
    end

    typedef struct packed {
        logic [NM-1:0]    valid;
        logic [NM*AW-1:0] addr;
        logic [NM*DW-1:0] data;
        logic [NM-1:0]    exp_ready;
        logic [NM-1:0]    exp_denied;
        logic             exp_wr_en;
    } vec_t;

    vec_t vecs [10];

    initial begin
        // {M2, M1, M0} packing on addr/data
        vecs[0] = '{3'b001, {8'h00, 8'h00, 8'h85}, {8'h00, 8'h00, 8'hA5}, 3'b001, 3'b000, 1'b0};
        vecs[1] = '{3'b000, {8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00}, 3'b000, 3'b000, 1'b1};
        vecs[2] = '{3'b100, {8'h10, 8'h00, 8'h00}, {8'h11, 8'h00, 8'h00}, 3'b100, 3'b100, 1'b0};
        vecs[3] = '{3'b000, {8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00}, 3'b000, 3'b000, 1'b0};
        vecs[4] = '{3'b011, {8'h00, 8'h13, 8'h0C}, {8'h00, 8'h22, 8'h21}, 3'b001, 3'b000, 1'b0};
        vecs[5] = '{3'b011, {8'h00, 8'h13, 8'h0C}, {8'h00, 8'h22, 8'h21}, 3'b010, 3'b000, 1'b1};
        vecs[6] = '{3'b111, {8'h0F, 8'h13, 8'h0C}, {8'h23, 8'h22, 8'h21}, 3'b100, 3'b000, 1'b1};
        vecs[7] = '{3'b010, {8'h00, 8'h80, 8'h00}, {8'h00, 8'h24, 8'h00}, 3'b010, 3'b010, 1'b1};
        vecs[8] = '{3'b001, {8'h00, 8'h00, 8'hC0}, {8'h00, 8'h00, 8'h25}, 3'b001, 3'b001, 1'b0};
        vecs[9] = '{3'b000, {8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00}, 3'b000, 3'b000, 1'b0};

        rst_n      = 1'b0;
        req_valid  = 3'b111;
        req_addr   = {8'h0F, 8'h0F, 8'h0F};
        req_data   = '0;
        wr_ready   = 1'b1;
        clear_viol = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check("rst_wr_master", {30'd0, wr_master}, 32'd0);
        check("rst_ready", {29'd0, req_ready}, 32'd0);
        check("rst_denied", {29'd0, req_denied}, 32'd0);
        check("rst_viol", {8'd0, viol_count}, 32'd0);
        req_valid = '0;

        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        for (int i = 0; i < 10; i++) begin
            req_valid = vecs[i].valid;
            req_addr  = vecs[i].addr;
            req_data  = vecs[i].data;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), {29'd0, req_ready}, {29'd0, vecs[i].exp_ready});
            check($sformatf("vec%0d_denied", i), {29'd0, req_denied}, {29'd0, vecs[i].exp_denied});
            check($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, {31'd0, vecs[i].exp_wr_en});
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        check("vec_cnt0", cnt(0), 32'd1);
        check("vec_cnt1", cnt(1), 32'd1);
        check("vec_cnt2", cnt(2), 32'd1);

        // Repeated M2 denials saturate its counter.
        req_valid = 3'b100;
        req_addr  = {8'h10, 8'h00, 8'h00};
        repeat (300) @(posedge clk);
        #1;
        req_valid = '0;
        check("sat_cnt2", cnt(2), 32'd255);
        check("sat_wr_en", {31'd0, wr_en}, 32'd0);

        // All masters continuously valid: strict rotation, full throughput.
        req_valid = 3'b111;
        req_addr  = {8'h0F, 8'h0F, 8'h0F};
        req_data  = {8'h32, 8'h31, 8'h30};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("rr_order%0d", k), {29'd0, req_ready}, 32'(1 << (k % 3)));
            if (k > 0) check($sformatf("rr_wr_en%0d", k), {31'd0, wr_en}, 32'd1);
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        @(negedge clk);
        check("rr_last_wr_en", {31'd0, wr_en}, 32'd1);
        @(posedge clk);
        #1;

        // Backpressure with a full stage, then release.
        req_valid = 3'b001;
        req_addr  = {8'h00, 8'h00, 8'h0F};
        req_data  = {8'h00, 8'h00, 8'h44};
        @(posedge clk);
        #1;
        req_valid = 3'b010;
        req_addr  = {8'h00, 8'h0F, 8'h00};
        req_data  = {8'h00, 8'h55, 8'h00};
        wr_ready  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_ready", {29'd0, req_ready}, 32'd0);
            check("stall_wr_en", {31'd0, wr_en}, 32'd1);
            check("stall_addr", {24'd0, wr_addr}, 32'h0F);
            check("stall_data", {24'd0, wr_data}, 32'h44);
            check("stall_master", {30'd0, wr_master}, 32'd0);
            @(posedge clk);
            #1;
        end
        wr_ready = 1'b1;
        @(negedge clk);
        check("release_ready", {29'd0, req_ready}, 32'b010);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("release_wr_en", {31'd0, wr_en}, 32'd1);
        check("release_data", {24'd0, wr_data}, 32'h55);
        check("release_master", {30'd0, wr_master}, 32'd1);
        @(posedge clk);
        #1;

        // Clear coinciding with a denial, then clear alone.
        req_valid = 3'b010;
        req_addr  = {8'h00, 8'h80, 8'h00};
        @(posedge clk);
        #1;
        check("pre_clear_cnt1", cnt(1), 32'd2);
        clear_viol = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = '0;
        clear_viol = 1'b0;
        check("clear_inc_cnt1", cnt(1), 32'd1);
        check("clear_cnt0", cnt(0), 32'd0);
        check("clear_cnt2", cnt(2), 32'd0);
        clear_viol = 1'b1;
        @(posedge clk);
        #1;
        clear_viol = 1'b0;
        check("clear_only_cnt1", cnt(1), 32'd0);

        // Reset in the middle of a held transfer.
        req_valid = 3'b100;
        req_addr  = {8'h10, 8'h00, 8'h00};
        @(posedge clk);
        #1;
        req_valid = 3'b010;
        req_addr  = {8'h00, 8'h0F, 8'h00};
        req_data  = {8'h00, 8'h66, 8'h00};
        check("pre_rst_cnt2", cnt(2), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 3'b111;
        req_addr  = {8'h0F, 8'h0F, 8'h0F};
        req_data  = {8'h72, 8'h71, 8'h70};
        wr_ready  = 1'b0;
        check("pre_rst_wr_en", {31'd0, wr_en}, 32'd1);
        check("pre_rst_data", {24'd0, wr_data}, 32'h66);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", {31'd0, wr_en}, 32'd0);
        check("midrst_wr_addr", {24'd0, wr_addr}, 32'd0);
        check("midrst_wr_data", {24'd0, wr_data}, 32'd0);
        check("midrst_ready", {29'd0, req_ready}, 32'd0);
        check("midrst_viol", {8'd0, viol_count}, 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {29'd0, req_ready}, 32'b001);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check("post_rst_wr_en", {31'd0, wr_en}, 32'd1);
        check("post_rst_data", {24'd0, wr_data}, 32'h70);
        check("post_rst_master", {30'd0, wr_master}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
